// File: rtl/node_accum_pipe.sv
// node_accum_pipe: read-modify-write accumulator in front of node_memory.
// Each accepted (address, signed delta) update reads the node word, adds the
// delta and writes the sum back after RD_LAT+2 cycles. A short write history
// forwards results that the memory read cannot see yet. Every commit is also
// queued into a small output FIFO for the downstream stage.
module node_accum_pipe #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 36,
  parameter int DELTA_W   = 16,
  parameter int RD_LAT    = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DELTA_W-1:0] in_delta,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] wraddr,
  output logic              wren,
  output logic [DATA_W-1:0] wrdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  // Delay line carrying each update alongside its outstanding memory read.
  logic               r_pv [0:RD_LAT];
  logic [ADDR_W-1:0]  r_pa [0:RD_LAT];
  logic [DELTA_W-1:0] r_pd [0:RD_LAT];

  logic [ADDR_W-1:0]  r_rdaddr;
  logic [ADDR_W-1:0]  r_wraddr;
  logic [DATA_W-1:0]  r_wrdata;
  logic               r_wren;

  // Older writes not yet visible to the read now returning; the current
  // write register is the newest history entry.
  logic               r_hv [1:RD_LAT];
  logic [ADDR_W-1:0]  r_ha [1:RD_LAT];
  logic [DATA_W-1:0]  r_hd [1:RD_LAT];

  logic [ADDR_W-1:0]  r_fa [0:OUT_DEPTH-1];
  logic [DATA_W-1:0]  r_fd [0:OUT_DEPTH-1];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_inflight;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [CW:0]        w_used;
  logic [DATA_W-1:0]  w_base;
  logic [DATA_W-1:0]  w_sum;

  // FIFO slots already promised (stored or still in flight) bound admission.
  assign w_used   = {1'b0, r_cnt} + {1'b0, r_inflight};
  assign in_ready = rst_n & (w_used < (CW+1)'(OUT_DEPTH));
  assign w_accept = in_valid & in_ready;
  assign w_push   = r_wren;
  assign w_pop    = (r_cnt != '0) & out_ready;

  // Pick the freshest value for the node in the add stage, newest match wins.
  always_comb begin
    w_base = q;
    for (int k = RD_LAT; k >= 1; k--) begin
      w_base = (r_hv[k] && (r_ha[k] == r_pa[RD_LAT])) ? r_hd[k] : w_base;
    end
    if (r_wren && (r_wraddr == r_pa[RD_LAT])) begin
      w_base = r_wrdata;
    end else begin
      w_base = w_base;
    end
    w_sum = w_base + DATA_W'($signed(r_pd[RD_LAT]));
  end

  // Update delay line and memory read address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdaddr <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pa[k] <= '0;
        r_pd[k] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pa[0] <= in_addr;
      r_pd[0] <= in_delta;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pa[k] <= r_pa[k-1];
        r_pd[k] <= r_pd[k-1];
      end
      if (w_accept) begin
        r_rdaddr <= in_addr;
      end else begin
        r_rdaddr <= r_rdaddr;
      end
    end
  end

  // Commit register and write history shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wren   <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_hv[k] <= 1'b0;
        r_ha[k] <= '0;
        r_hd[k] <= '0;
      end
    end else begin
      r_wren <= r_pv[RD_LAT];
      if (r_pv[RD_LAT]) begin
        r_wraddr <= r_pa[RD_LAT];
        r_wrdata <= w_sum;
      end else begin
        r_wraddr <= r_wraddr;
        r_wrdata <= r_wrdata;
      end
      r_hv[1] <= r_wren;
      r_ha[1] <= r_wraddr;
      r_hd[1] <= r_wrdata;
      for (int k = 2; k <= RD_LAT; k++) begin
        r_hv[k] <= r_hv[k-1];
        r_ha[k] <= r_ha[k-1];
        r_hd[k] <= r_hd[k-1];
      end
    end
  end

  // Output FIFO storage, pointers, occupancy and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        r_fa[k] <= '0;
        r_fd[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fa[r_wp] <= r_wraddr;
        r_fd[r_wp] <= r_wrdata;
        r_wp       <= r_wp + P_ONE;
      end else begin
        r_wp <= r_wp;
      end
      if (w_pop) begin
        r_rp <= r_rp + P_ONE;
      end else begin
        r_rp <= r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + C_ONE;
        2'b01:   r_inflight <= r_inflight - C_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign rdaddr    = r_rdaddr;
  assign wraddr    = r_wraddr;
  assign wrdata    = r_wrdata;
  assign wren      = r_wren & rst_n;
  assign out_valid = (r_cnt != '0);
  assign out_addr  = r_fa[r_rp];
  assign out_data  = r_fd[r_rp];
  assign busy      = (r_inflight != '0) | (r_cnt != '0);

endmodule
